muldiv_arbiter: RTL and testbench

//  Shares one MulDivModule between NUM_REQ requesters (e.g. execute lanes) with

---
 rtl/muldiv_arbiter_pkg.sv | 34 +++
 rtl/muldiv_arbiter_rr_pick.sv | 34 +++
 rtl/muldiv_arbiter.sv | 140 ++++++++++++++
 tb/tb_muldiv_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_arbiter_pkg.sv
// muldiv_arbiter_pkg: shared types for the mul/div arbiter slice.
//   alu_sel_e       : ALU/mul-div operation select (AluSel)
//   md_arb_state_e  : arbiter FSM state (MdArbState)
//   uint_x_t        : XLEN-wide unsigned datapath word (UIntX)
package muldiv_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] uint_x_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_MULH,
        ALU_DIV,
        ALU_REM
    } alu_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_ISSUE = 2'd1,
        MD_BUSY  = 2'd2,
        MD_DRAIN = 2'd3
    } md_arb_state_e;

endpackage

// File: rtl/muldiv_arbiter_rr_pick.sv
// muldiv_arbiter_rr_pick: combinational round-robin one-hot selector.
//   req  in  N   request vector
//   ptr  in  IW  highest-priority index this cycle
//   gnt  out N   one-hot grant (zero when no request)
//   idx  out IW  index of the granted request
//   any  out 1   some request present
module muldiv_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the nearest match to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin share of one MulDivModule between NUM_REQ requesters.
//   req_valid/sel/signed/op1/op2  in   per-requester operation
//   req_ready                     out  one-hot grant (IDLE only)
//   kill                          in   per-requester flush
//   resp_valid/resp_result        out  one-hot result strobe and data
//   busy                          out  FSM not idle
//   md_req_*                      out  registered request to MulDivModule
//   md_req_ready                  in   MulDivModule accepts request
//   md_resp_valid/result          in   MulDivModule result
module muldiv_arbiter
    import muldiv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  alu_sel_e [NUM_REQ-1:0]         req_sel,
    input  logic [NUM_REQ-1:0]             req_signed,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_op1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_op2,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             kill,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [XLEN-1:0]                resp_result,
    output logic                           busy,
    output logic                           md_req_valid,
    input  logic                           md_req_ready,
    output alu_sel_e                       md_req_sel,
    output logic                           md_req_signed,
    output logic [XLEN-1:0]                md_req_op1,
    output logic [XLEN-1:0]                md_req_op2,
    input  logic                           md_resp_valid,
    input  logic [XLEN-1:0]                md_resp_result
);

    md_arb_state_e   state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    alu_sel_e        sel_q, sel_d;
    logic            signed_q, signed_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               owner_kill;

    muldiv_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req_valid & ~kill),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_kill    = kill[owner_q];
    assign busy          = state_q != MD_IDLE;
    assign md_req_sel    = sel_q;
    assign md_req_signed = signed_q;
    assign md_req_op1    = op1_q;
    assign md_req_op2    = op2_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        signed_d     = signed_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        req_ready    = '0;
        resp_valid   = '0;
        resp_result  = '0;
        md_req_valid = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    owner_d   = pick_idx;
                    sel_d     = req_sel[pick_idx];
                    signed_d  = req_signed[pick_idx];
                    op1_d     = req_op1[pick_idx];
                    op2_d     = req_op2[pick_idx];
                    ptr_d     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                    state_d   = MD_ISSUE;
                end
            end
            MD_ISSUE: begin
                md_req_valid = 1'b1;
                // A kill before hand-over simply abandons the op; after hand-over
                // the unit still owes a result, so it must be drained.
                if (owner_kill)
                    state_d = md_req_ready ? MD_DRAIN : MD_IDLE;
                else if (md_req_ready)
                    state_d = MD_BUSY;
            end
            MD_BUSY: begin
                if (md_resp_valid) begin
                    if (!owner_kill) begin
                        resp_valid[owner_q] = 1'b1;
                        resp_result         = md_resp_result;
                    end
                    state_d = MD_IDLE;
                end else if (owner_kill) begin
                    state_d = MD_DRAIN;
                end
            end
            MD_DRAIN: begin
                if (md_resp_valid)
                    state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            sel_q    <= alu_sel_e'(4'd0);
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed self-checking bench for muldiv_arbiter.
module tb_muldiv_arbiter;
    import muldiv_arbiter_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req_valid;
    alu_sel_e [1:0]       req_sel;
    logic [1:0]           req_signed;
    logic [1:0][31:0]     req_op1;
    logic [1:0][31:0]     req_op2;
    logic [1:0]           req_ready;
    logic [1:0]           kill;
    logic [1:0]           resp_valid;
    logic [31:0]          resp_result;
    logic                 busy;
    logic                 md_req_valid;
    logic                 md_req_ready;
    alu_sel_e             md_req_sel;
    logic                 md_req_signed;
    logic [31:0]          md_req_op1;
    logic [31:0]          md_req_op2;
    logic                 md_resp_valid;
    logic [31:0]          md_resp_result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_sel        (req_sel),
        .req_signed     (req_signed),
        .req_op1        (req_op1),
        .req_op2        (req_op2),
        .req_ready      (req_ready),
        .kill           (kill),
        .resp_valid     (resp_valid),
        .resp_result    (resp_result),
        .busy           (busy),
        .md_req_valid   (md_req_valid),
        .md_req_ready   (md_req_ready),
        .md_req_sel     (md_req_sel),
        .md_req_signed  (md_req_signed),
        .md_req_op1     (md_req_op1),
        .md_req_op2     (md_req_op2),
        .md_resp_valid  (md_resp_valid),
        .md_resp_result (md_resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 2ns after the next rising edge; inputs are driven here and
    // outputs are checked 1ns later, well clear of both clock edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_sel[0]     = ALU_ADD;
        req_sel[1]     = ALU_ADD;
        req_signed     = '0;
        req_op1        = '0;
        req_op2        = '0;
        kill           = '0;
        md_req_ready   = 1'b0;
        md_resp_valid  = 1'b0;
        md_resp_result = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_md_req_valid", md_req_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_op1", md_req_op1, 0);
        step();
        rst_n = 1'b1;

        // 1: single MUL 3*5
        step();
        req_valid  = 2'b01;
        req_sel[0] = ALU_MUL;
        req_op1[0] = 32'd3;
        req_op2[0] = 32'd5;
        #1;
        check("t1_req_ready", req_ready, 2'b01);
        check("t1_busy_idle", busy, 0);
        step();
        req_valid    = '0;
        md_req_ready = 1'b1;
        #1;
        check("t1_md_req_valid", md_req_valid, 1);
        check("t1_md_op1", md_req_op1, 3);
        check("t1_md_op2", md_req_op2, 5);
        check("t1_md_sel", md_req_sel, ALU_MUL);
        check("t1_busy", busy, 1);
        step();
        md_req_ready   = 1'b0;
        md_resp_valid  = 1'b1;
        md_resp_result = 32'd15;
        #1;
        check("t1_busy_md_req_valid", md_req_valid, 0);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_result", resp_result, 15);
        step();
        md_resp_valid = 1'b0;
        #1;
        check("t1_idle_busy", busy, 0);
        check("t1_idle_result", resp_result, 0);

        // 2: round robin after reset
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        step();
        req_valid  = 2'b11;
        req_op1[0] = 32'd7;
        req_op1[1] = 32'd9;
        #1;
        check("t2_first_grant", req_ready, 2'b01);
        step();
        md_req_ready = 1'b1;
        #1;
        check("t2_op1_req0", md_req_op1, 7);
        check("t2_no_ready_issue", req_ready, 0);
        step();
        md_req_ready   = 1'b0;
        md_resp_valid  = 1'b1;
        md_resp_result = 32'd1;
        #1;
        check("t2_resp0", resp_valid, 2'b01);
        step();
        md_resp_valid = 1'b0;
        #1;
        check("t2_second_grant", req_ready, 2'b10);
        step();
        md_req_ready = 1'b1;
        #1;
        check("t2_op1_req1", md_req_op1, 9);
        step();
        md_req_ready   = 1'b0;
        md_resp_valid  = 1'b1;
        md_resp_result = 32'd2;
        #1;
        check("t2_resp1", resp_valid, 2'b10);
        check("t2_result1", resp_result, 2);
        step();
        md_resp_valid = 1'b0;
        #1;
        check("t2_wrap_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        kill      = 2'b01;
        #1;
        check("t2_kill_issue_valid", md_req_valid, 1);
        step();
        kill = '0;
        #1;
        check("t2_kill_issue_idle", busy, 0);

        // 3: ISSUE stalls with stable fields
        req_valid     = 2'b01;
        req_sel[0]    = ALU_DIV;
        req_signed[0] = 1'b1;
        req_op1[0]    = 32'd100;
        req_op2[0]    = 32'd7;
        #1;
        check("t3_grant", req_ready, 2'b01);
        step();
        req_valid  = '0;
        req_op1[0] = 32'hffff_ffff;
        req_sel[0] = ALU_ADD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_valid", md_req_valid, 1);
            check("t3_stall_op1", md_req_op1, 100);
            check("t3_stall_op2", md_req_op2, 7);
            check("t3_stall_sel", md_req_sel, ALU_DIV);
            check("t3_stall_signed", md_req_signed, 1);
            step();
        end
        md_req_ready = 1'b1;
        step();
        md_req_ready = 1'b0;
        #1;
        check("t3_busy", busy, 1);
        check("t3_busy_no_req", md_req_valid, 0);
        md_resp_valid  = 1'b1;
        md_resp_result = 32'd14;
        #1;
        check("t3_resp", resp_valid, 2'b01);
        check("t3_result", resp_result, 14);
        step();
        md_resp_valid = 1'b0;

        // 4: kill owner in BUSY, then drain while req1 waits
        req_valid = 2'b01;
        #1;
        check("t4_grant0", req_ready, 2'b01);
        step();
        req_valid    = 2'b11;
        md_req_ready = 1'b1;
        step();
        md_req_ready = 1'b0;
        kill         = 2'b01;
        #1;
        check("t4_busy_kill_resp", resp_valid, 0);
        check("t4_busy_no_grant", req_ready, 0);
        step();
        kill = '0;
        #1;
        check("t4_drain_busy", busy, 1);
        check("t4_drain_no_grant", req_ready, 0);
        md_resp_valid  = 1'b1;
        md_resp_result = 32'hdead;
        #1;
        check("t4_drain_resp", resp_valid, 0);
        check("t4_drain_result", resp_result, 0);
        step();
        md_resp_valid = 1'b0;
        #1;
        check("t4_grant1", req_ready, 2'b10);
        step();
        req_valid = '0;
        kill      = 2'b10;
        step();
        kill = '0;

        // 5: kill on the same cycle as the result
        req_valid = 2'b10;
        #1;
        check("t5_grant1", req_ready, 2'b10);
        step();
        req_valid    = '0;
        md_req_ready = 1'b1;
        step();
        md_req_ready   = 1'b0;
        kill           = 2'b10;
        md_resp_valid  = 1'b1;
        md_resp_result = 32'd55;
        #1;
        check("t5_resp", resp_valid, 0);
        step();
        kill          = '0;
        md_resp_valid = 1'b0;
        #1;
        check("t5_busy_after", busy, 0);
        req_valid = 2'b11;
        kill      = 2'b01;
        #1;
        check("t5_kill_masks", req_ready, 2'b10);
        step();
        req_valid = '0;
        kill      = 2'b10;
        step();
        kill = '0;

        // 6: async reset in BUSY, stale response afterwards
        req_valid = 2'b01;
        #1;
        check("t6_grant", req_ready, 2'b01);
        step();
        req_valid    = '0;
        md_req_ready = 1'b1;
        step();
        md_req_ready = 1'b0;
        #1;
        check("t6_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", busy, 0);
        check("t6_async_md_valid", md_req_valid, 0);
        check("t6_async_op1", md_req_op1, 0);
        step();
        rst_n = 1'b1;
        step();
        md_resp_valid  = 1'b1;
        md_resp_result = 32'h1234;
        #1;
        check("t6_stale_resp", resp_valid, 0);
        check("t6_stale_result", resp_result, 0);
        step();
        md_resp_valid = 1'b0;
        #1;
        check("t6_stale_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
